if_prefetch_stage: RTL and testbench

Parametrised instruction-fetch stage that decouples the PC sequencer from a variable-latency instruction memory (SRAM-backed) through a DEPTH-entry prefetch queue. It issues in-order word fetches ahead of decode, holds returned instructions with their PC+4, and presents them to the IF/ID register under the pipeline's freeze/branch controls. Branches flush the queue and discard in-flight responses.

---
 rtl/if_prefetch_stage_if.sv | 35 +++
 rtl/if_prefetch_stage.sv | 176 +++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_stage_if.sv
// if_prefetch_stage_if
//   Instruction-memory request/response bundle between the prefetch stage
//   (master) and the SRAM-backed instruction memory (slave).
//
//   req     master -> slave  fetch request valid
//   addr    master -> slave  fetch address (ADDR_W)
//   ready   slave -> master  memory accepts the request this cycle
//   rvalid  slave -> master  response valid (in order, >=1 cycle after accept)
//   rdata   slave -> master  response data (DATA_W)
interface if_prefetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
//   Instruction-fetch stage: issues in-order word fetches ahead of decode into
//   a DEPTH-entry prefetch queue, and presents the head entry (instruction and
//   its PC+4) to the IF/ID register under freeze/branch control. A branch
//   flushes the queue and discards responses still in flight.
//
//   Optional feature macro: IF_PREFETCH_BYPASS_EN
//     defined   - a kept response arriving while the queue is empty drives the
//                 outputs combinationally in that cycle (and is not queued if
//                 it is consumed at once).
//     undefined - outputs come only from the queue head register.
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   freeze        downstream stall; head entry is not consumed
//   branch_taken  redirect request (overrides freeze)
//   branch_addr   redirect target
//   imem          instruction-memory bundle (master modport)
//   valid         instruction/pc hold a real fetched entry
//   instruction   head instruction, NOP_INSTR when !valid
//   pc            head address + 4, 0 when !valid
module if_prefetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'hE1A00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    if_prefetch_stage_if.master imem,
    output logic              valid,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] fill_pc_q, fill_pc_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW:0]       inflight;
    logic              accept;
    logic              keep;
    logic              head_valid;
    logic              push;
    logic              pop_q;

    // Queued plus outstanding fetches never exceed DEPTH, so every response
    // that is kept always has a free queue slot.
    assign inflight   = {1'b0, count_q} + {1'b0, outst_q};
    assign imem.req   = rst & ~branch_taken & (inflight < (CW+1)'(DEPTH));
    assign imem.addr  = fetch_pc_q;
    assign accept     = imem.req & imem.ready;
    assign keep       = imem.rvalid & (discard_q == '0);
    assign head_valid = (count_q != '0);

`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass;
    logic pop;

    assign bypass = rst & keep & ~head_valid & ~branch_taken;

    always_comb begin
        valid       = head_valid | bypass;
        instruction = NOP_INSTR;
        pc          = '0;
        if (head_valid) begin
            instruction = q_data[rd_ptr_q];
            pc          = q_addr[rd_ptr_q] + STEP;
        end else if (bypass) begin
            instruction = imem.rdata;
            pc          = fill_pc_q + STEP;
        end
        pop   = valid & ~freeze & ~branch_taken;
        // A bypassed response consumed in the same cycle never enters the queue.
        push  = keep & ~branch_taken & ~(bypass & pop);
        pop_q = pop & head_valid;
    end
`else
    always_comb begin
        valid       = head_valid;
        instruction = NOP_INSTR;
        pc          = '0;
        if (head_valid) begin
            instruction = q_data[rd_ptr_q];
            pc          = q_addr[rd_ptr_q] + STEP;
        end
        push  = keep & ~branch_taken;
        pop_q = head_valid & ~freeze & ~branch_taken;
    end
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fill_pc_d  = fill_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(accept) - CW'(imem.rvalid);
        count_d    = count_q + CW'(push) - CW'(pop_q);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + STEP;
        end
        if (imem.rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
        if (keep && !branch_taken) begin
            fill_pc_d = fill_pc_q + STEP;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_q) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Every fetch still outstanding after this cycle belongs to the old
        // stream, so all of them are marked for discard.
        if (branch_taken) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = branch_addr;
            fill_pc_d  = branch_addr;
            discard_d  = outst_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            fill_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fill_pc_q  <= fill_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr_q] <= fill_pc_q;
            q_data[wr_ptr_q] <= imem.rdata;
        end
    end

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst) imem.rvalid |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;

    if_prefetch_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem_if ();

    if_prefetch_stage #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem        (imem_if),
        .valid       (valid),
        .instruction (instruction),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Memory content: every word is a fixed function of its address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } pend_t;

    // Reference model: memory requests in flight (tagged with the stream epoch
    // they were issued in) and the in-order list of fetched addresses that
    // are waiting to be consumed.
    pend_t       pend[$];
    logic [31:0] mq[$];
    logic [31:0] m_fetch = RESET_PC;
    int unsigned epoch = 0;
    int unsigned cyc = 0;
    int unsigned n_accept = 0;
    int unsigned n_dropped = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned ready_pct = 100;

    int total = 0;
    int bad = 0;

    logic        s_valid, s_req;
    logic [31:0] s_pc, s_instr, s_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: no valid within bound (cycle %0d)", name, cyc);
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs 1 ns
    // later against the model, advance the model, then wait for the next
    // falling edge.
    task automatic tick(input logic r, input logic frz, input logic br, input logic [31:0] baddr);
        logic  rdy;
        logic  deliver;
        logic  acc;
        logic  exp_req;
        pend_t h;
        rst          = r;
        freeze       = frz;
        branch_taken = br;
        branch_addr  = baddr;
        if (!r) begin
            pend.delete();
            mq.delete();
            m_fetch = RESET_PC;
            epoch++;
        end
        rdy     = ($urandom_range(99) < ready_pct);
        deliver = r && (pend.size() != 0) && (pend[0].due <= cyc);
        imem_if.ready  = rdy;
        imem_if.rvalid = deliver;
        imem_if.rdata  = deliver ? mdata(pend[0].addr) : $urandom;
        #1;
        s_valid = valid;
        s_pc    = pc;
        s_instr = instruction;
        s_req   = imem_if.req;
        s_addr  = imem_if.addr;

        exp_req = r && !br && ((mq.size() + pend.size()) < DEPTH);
        chk("valid", 32'(s_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("pc", s_pc, mq[0] + 32'd4);
            chk("instruction", s_instr, mdata(mq[0]));
        end else begin
            chk("pc_idle", s_pc, 32'h0);
            chk("instruction_idle", s_instr, NOP);
        end
        chk("imem_req", 32'(s_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", s_addr, m_fetch);

        acc = s_req && rdy;
        if (r) begin
            if (!br && (mq.size() != 0) && !frz) void'(mq.pop_front());
            if (deliver) begin
                h = pend.pop_front();
                if (!br && h.epoch == epoch) mq.push_back(h.addr);
                else n_dropped++;
            end
            if (acc) begin
                h.addr  = s_addr;
                h.epoch = epoch;
                h.due   = cyc + $urandom_range(lat_max, lat_min);
                pend.push_back(h);
                m_fetch = m_fetch + 32'd4;
                n_accept++;
            end
            if (br) begin
                mq.delete();
                epoch++;
                m_fetch = baddr;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int unsigned d0;
        int unsigned goal;
        imem_if.ready  = 1'b0;
        imem_if.rvalid = 1'b0;
        imem_if.rdata  = '0;
        @(negedge clk);

        // Reset state
        repeat (2) tick(1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset_valid", 32'(s_valid), 32'h0);
        chk("reset_req", 32'(s_req), 32'h0);
        chk("reset_instr", s_instr, NOP);
        chk("reset_pc", s_pc, 32'h0);

        // Zero-wait streaming from reset
        lat_min = 1; lat_max = 1; ready_pct = 100;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("first_req", 32'(s_req), 32'h1);
        chk("first_addr", s_addr, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("cycle1_valid", 32'(s_valid), 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("cycle2_valid", 32'(s_valid), 32'h1);
        chk("cycle2_pc", s_pc, 32'h4);
        chk("cycle2_instr", s_instr, 32'h5A5A0000);

        // Freeze for 10 cycles starting with pc = 8 showing
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            chk("freeze_pc", s_pc, 32'h8);
            chk("freeze_instr", s_instr, 32'h5A5A0004);
        end
        chk("freeze_req_off", 32'(s_req), 32'h0);
        chk("freeze_model_full", 32'(mq.size()), 32'(DEPTH));
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("unfreeze_pc0", s_pc, 32'h8);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("unfreeze_pc1", s_pc, 32'hC);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("unfreeze_pc2", s_pc, 32'h10);

        // Branch with three fetches outstanding
        ready_pct = 0;
        tick(1'b1, 1'b0, 1'b1, 32'h80);
        repeat (8) tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("drain_pending", 32'(pend.size()), 32'h0);
        ready_pct = 100; lat_min = 5; lat_max = 5;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("three_outstanding", 32'(pend.size()), 32'h3);
        d0 = n_dropped;
        tick(1'b1, 1'b0, 1'b1, 32'h100);
        for (k = 0; k < 40; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            if (s_valid) break;
        end
        if (k == 40) timeout("branch_target");
        chk("branch_drops", 32'(n_dropped - d0), 32'h3);
        chk("branch_pc", s_pc, 32'h104);
        chk("branch_instr", s_instr, 32'h5A5A0100);

        // Branch together with freeze, target near the top of the address space
        lat_min = 1; lat_max = 1;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("flush_wins", 32'(s_valid), 32'h0);
        for (k = 0; k < 20; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            if (s_valid) break;
        end
        if (k == 20) timeout("wrap_target");
        chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", s_instr, 32'hA5A5_FFF8);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc1", s_pc, 32'h0);
        chk("wrap_instr1", s_instr, 32'hA5A5_FFFC);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc2", s_pc, 32'h4);
        chk("wrap_instr2", s_instr, 32'h5A5A_0000);

        // Reset pulse mid-stream with two fetches outstanding
        lat_min = 2; lat_max = 2;
        repeat (6) tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("two_outstanding", 32'(pend.size()), 32'h2);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        chk("midreset_valid", 32'(s_valid), 32'h0);
        chk("midreset_instr", s_instr, NOP);
        chk("midreset_pc", s_pc, 32'h0);
        chk("midreset_req", 32'(s_req), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("restart_req", 32'(s_req), 32'h1);
        chk("restart_addr", s_addr, RESET_PC);
        for (k = 0; k < 20; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            if (s_valid) break;
        end
        if (k == 20) timeout("restart");
        chk("restart_pc", s_pc, 32'h4);

        // Random ready, latency, freeze and branches over 500 fetches
        lat_min = 1; lat_max = 5; ready_pct = 60;
        goal = n_accept + 500;
        for (k = 0; k < 20000 && n_accept < goal; k++) begin
            tick(1'b1, ($urandom_range(99) < 20), ($urandom_range(99) < 2),
                 $urandom & 32'hFFFF_FFFC);
        end
        if (n_accept < goal) timeout("random_fetches");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
